// File: rtl/multicycle_control.sv
// Purpose: multicycle CPU control FSM with memory-wait timeout, sticky fault and retire counter.
// Latency: one state per clock; datapath controls decode combinationally from the current state.
// Backpressure: MemReady stalls FETCH/MEMREAD/MEMWRITE; a stall of MEM_TIMEOUT cycles halts with Fault.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  State,
  output logic        Fault,
  output logic [15:0] RetireCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Last wait-count value tolerated before a missing MemReady becomes a fault.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        fault_q, fault_set;
  logic [15:0] retire_cnt;
  logic        retire_inc;
  logic        in_wait;
  logic        timeout;

  assign State       = state_q;
  assign Fault       = fault_q;
  assign RetireCount = retire_cnt;

  // Memory-facing states count stalled cycles; MemReady in the final cycle still wins.
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout = in_wait && !MemReady && (wait_q == WAIT_LAST);

  // Register state, wait counter, sticky fault and retire counter; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_q     <= 8'd0;
      fault_q    <= 1'b0;
      retire_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (fault_set) begin
        fault_q <= 1'b1;
      end
      if (retire_inc) begin
        retire_cnt <= retire_cnt + 16'd1;
      end
    end
  end

  // Next-state selection, fault detection and retirement detection.
  always_comb begin
    state_d    = state_q;
    fault_set  = 1'b0;
    retire_inc = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          fault_set = 1'b1;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d   = S_HALT;
            fault_set = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d   = S_HALT;
          fault_set = 1'b1;
        end
      end
      S_MEMWB: begin
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_MEMWRITE: begin
        if (MemReady) begin
          state_d    = S_FETCH;
          retire_inc = 1'b1;
        end else if (timeout) begin
          state_d   = S_HALT;
          fault_set = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_BRANCH: begin
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Any state change is an entry into a new state, which restarts the wait count.
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (in_wait && !MemReady) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Datapath control decode from the current state; only FETCH looks at MemReady.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
